id_stage_gen2: RTL and testbench

Second-generation decode stage for the 5-stage ARM pipeline, sitting between IF and EXE.
- Carries a parametrised-width register file.
- Performs RAW hazard detection internally (the previous stage took `hazard` as an input).
- Optionally bypasses same-cycle WB writes.
- Drives a registered ID/EX pipeline boundary with valid, stall (hold) and flush (bubble) control.
- Decode, condition evaluation and register-field selection match the existing Control_Unit / Condition_Check semantics.

---
 rtl/id_stage_gen2.sv | 255 +++++++++++++++++++++++++
 tb/tb_id_stage_gen2.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_gen2.sv
// ARM decode stage: 16-entry register file, internal RAW hazard detection,
// optional same-cycle write-back bypass and a registered ID/EX boundary.
module id_stage_gen2 #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned PC_WIDTH      = 32,
   parameter int unsigned WB_BYPASS     = 1,
   parameter int unsigned HAZ_MEM_CHECK = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid,
   input  logic [PC_WIDTH-1:0]   PC_in,
   input  logic [31:0]           instruction_in,
   input  logic [3:0]            Status_Register,
   input  logic                  stall_in,
   input  logic                  flush,
   input  logic                  WB_EN,
   input  logic [3:0]            WB_Dest,
   input  logic [DATA_WIDTH-1:0] WB_Value,
   input  logic                  EXE_WB_EN,
   input  logic [3:0]            EXE_Dest,
   input  logic                  MEM_WB_EN,
   input  logic [3:0]            MEM_Dest,
   output logic                  hazard_out,
   output logic                  valid_out,
   output logic                  MEM_R_EN_out,
   output logic                  MEM_W_EN_out,
   output logic                  WB_EN_out,
   output logic                  Imm_out,
   output logic                  B_out,
   output logic                  S_out,
   output logic [3:0]            EX_CMD_out,
   output logic [3:0]            Reg_src1,
   output logic [3:0]            Reg_src2,
   output logic [3:0]            Reg_Dest,
   output logic [11:0]           shifter_operand,
   output logic [23:0]           signed_immediate,
   output logic [PC_WIDTH-1:0]   PC_out,
   output logic [DATA_WIDTH-1:0] Val_Rn,
   output logic [DATA_WIDTH-1:0] Val_Rm,
   output logic [3:0]            SR_out
);

   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;
   localparam logic [3:0] CMD_MVN = 4'b1001;

   typedef struct packed {
      logic                  valid;
      logic                  memR;
      logic                  memW;
      logic                  wb;
      logic                  imm;
      logic                  branch;
      logic                  sUpd;
      logic [3:0]            exCmd;
      logic [3:0]            src1;
      logic [3:0]            src2;
      logic [3:0]            dest;
      logic [11:0]           shOp;
      logic [23:0]           sImm;
      logic [PC_WIDTH-1:0]   pc;
      logic [DATA_WIDTH-1:0] valRn;
      logic [DATA_WIDTH-1:0] valRm;
      logic [3:0]            sr;
   } idex_t;

   logic [1:0] mode;
   logic [3:0] opcode;
   logic [3:0] cond;
   logic       immBit;
   logic       sBit;

   assign cond   = instruction_in[31:28];
   assign mode   = instruction_in[27:26];
   assign immBit = instruction_in[25];
   assign opcode = instruction_in[24:21];
   assign sBit   = instruction_in[20];

   logic [3:0] exCmd;
   logic       wbEn;
   logic       memREn;
   logic       memWEn;
   logic       branch;
   logic       sUpd;

   // Unrecognised data-processing opcodes decode to a NOP.
   always_comb begin
      exCmd  = 4'b0000;
      wbEn   = 1'b0;
      memREn = 1'b0;
      memWEn = 1'b0;
      branch = 1'b0;
      sUpd   = 1'b0;
      case (mode)
         2'b00: begin
            sUpd = sBit;
            wbEn = 1'b1;
            case (opcode)
               4'b1101: exCmd = CMD_MOV;
               4'b1111: exCmd = CMD_MVN;
               4'b0100: exCmd = CMD_ADD;
               4'b0101: exCmd = CMD_ADC;
               4'b0010: exCmd = CMD_SUB;
               4'b0110: exCmd = CMD_SBC;
               4'b0000: exCmd = CMD_AND;
               4'b1100: exCmd = CMD_ORR;
               4'b0001: exCmd = CMD_EOR;
               4'b1010: begin exCmd = CMD_SUB; wbEn = 1'b0; end
               4'b1000: begin exCmd = CMD_AND; wbEn = 1'b0; end
               default: begin wbEn = 1'b0; sUpd = 1'b0; end
            endcase
         end
         2'b01: begin
            exCmd  = CMD_ADD;
            memREn = sBit;
            memWEn = ~sBit;
            wbEn   = sBit;
         end
         2'b10: branch = 1'b1;
         default: ;
      endcase
   end

   logic flagN, flagZ, flagC, flagV;
   logic condPass;

   assign {flagN, flagZ, flagC, flagV} = Status_Register;

   always_comb begin
      condPass = 1'b0;
      case (cond)
         4'h0: condPass = flagZ;
         4'h1: condPass = ~flagZ;
         4'h2: condPass = flagC;
         4'h3: condPass = ~flagC;
         4'h4: condPass = flagN;
         4'h5: condPass = ~flagN;
         4'h6: condPass = flagV;
         4'h7: condPass = ~flagV;
         4'h8: condPass = flagC & ~flagZ;
         4'h9: condPass = ~flagC | flagZ;
         4'hA: condPass = (flagN == flagV);
         4'hB: condPass = (flagN != flagV);
         4'hC: condPass = ~flagZ & (flagN == flagV);
         4'hD: condPass = flagZ | (flagN != flagV);
         4'hE: condPass = 1'b1;
         default: condPass = 1'b0;
      endcase
   end

   logic [DATA_WIDTH-1:0] regFile_q [16];

   // Write-back keeps landing in the register file even while ID/EX is held.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) regFile_q[i] <= '0;
      end else if (WB_EN) begin
         regFile_q[WB_Dest] <= WB_Value;
      end
   end

   logic [3:0]            src1;
   logic [3:0]            src2;
   logic [DATA_WIDTH-1:0] rdVal1;
   logic [DATA_WIDTH-1:0] rdVal2;
   logic                  bypass1;
   logic                  bypass2;

   assign src1    = instruction_in[19:16];
   assign src2    = memWEn ? instruction_in[15:12] : instruction_in[3:0];
   assign bypass1 = (WB_BYPASS != 0) && WB_EN && (WB_Dest == src1);
   assign bypass2 = (WB_BYPASS != 0) && WB_EN && (WB_Dest == src2);
   assign rdVal1  = bypass1 ? WB_Value : regFile_q[src1];
   assign rdVal2  = bypass2 ? WB_Value : regFile_q[src2];

   logic withSrc1;
   logic withSrc2;
   logic match1;
   logic match2;

   assign withSrc1 = !((exCmd == CMD_MOV) || (exCmd == CMD_MVN) || branch);
   assign withSrc2 = memWEn | ~immBit;
   assign match1   = (EXE_WB_EN && (EXE_Dest == src1)) ||
                     ((HAZ_MEM_CHECK != 0) && MEM_WB_EN && (MEM_Dest == src1));
   assign match2   = (EXE_WB_EN && (EXE_Dest == src2)) ||
                     ((HAZ_MEM_CHECK != 0) && MEM_WB_EN && (MEM_Dest == src2));

   assign hazard_out = instr_valid && !flush &&
                       ((withSrc1 && match1) || (withSrc2 && match2));

   idex_t idex_d;
   idex_t idex_q;

   // A failed condition still occupies the slot, with every control cleared.
   always_comb begin
      idex_d = idex_q;
      if (stall_in) begin
         idex_d = idex_q;
      end else if (flush || !instr_valid || hazard_out) begin
         idex_d = '0;
      end else begin
         idex_d        = '0;
         idex_d.valid  = 1'b1;
         idex_d.src1   = src1;
         idex_d.src2   = src2;
         idex_d.dest   = instruction_in[15:12];
         idex_d.shOp   = instruction_in[11:0];
         idex_d.sImm   = instruction_in[23:0];
         idex_d.pc     = PC_in;
         idex_d.valRn  = rdVal1;
         idex_d.valRm  = rdVal2;
         idex_d.sr     = Status_Register;
         if (condPass) begin
            idex_d.memR   = memREn;
            idex_d.memW   = memWEn;
            idex_d.wb     = wbEn;
            idex_d.imm    = immBit;
            idex_d.branch = branch;
            idex_d.sUpd   = sUpd;
            idex_d.exCmd  = exCmd;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) idex_q <= '0;
      else     idex_q <= idex_d;
   end

   assign valid_out        = idex_q.valid;
   assign MEM_R_EN_out     = idex_q.memR;
   assign MEM_W_EN_out     = idex_q.memW;
   assign WB_EN_out        = idex_q.wb;
   assign Imm_out          = idex_q.imm;
   assign B_out            = idex_q.branch;
   assign S_out            = idex_q.sUpd;
   assign EX_CMD_out       = idex_q.exCmd;
   assign Reg_src1         = idex_q.src1;
   assign Reg_src2         = idex_q.src2;
   assign Reg_Dest         = idex_q.dest;
   assign shifter_operand  = idex_q.shOp;
   assign signed_immediate = idex_q.sImm;
   assign PC_out           = idex_q.pc;
   assign Val_Rn           = idex_q.valRn;
   assign Val_Rm           = idex_q.valRm;
   assign SR_out           = idex_q.sr;

endmodule

// File: tb/tb_id_stage_gen2.sv
// Bench for id_stage_gen2: one instance with bypass and MEM hazard checking,
// one without, both against an instruction-level reference model.
module tb_id_stage_gen2;

   localparam int DW = 32;
   localparam int PW = 32;
   localparam int VW = 7 + 16 + 12 + 24 + PW + 2 * DW + 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          instr_valid;
   logic [PW-1:0] PC_in;
   logic [31:0]   instruction_in;
   logic [3:0]    Status_Register;
   logic          stall_in;
   logic          flush;
   logic          WB_EN;
   logic [3:0]    WB_Dest;
   logic [DW-1:0] WB_Value;
   logic          EXE_WB_EN;
   logic [3:0]    EXE_Dest;
   logic          MEM_WB_EN;
   logic [3:0]    MEM_Dest;

   logic          hazA, validA, memRA, memWA, wbA, immA, bA, sA;
   logic [3:0]    cmdA, src1A, src2A, destA, srA;
   logic [11:0]   shA;
   logic [23:0]   simmA;
   logic [PW-1:0] pcA;
   logic [DW-1:0] rnA, rmA;

   logic          hazB, validB, memRB, memWB, wbB, immB, bB, sB;
   logic [3:0]    cmdB, src1B, src2B, destB, srB;
   logic [11:0]   shB;
   logic [23:0]   simmB;
   logic [PW-1:0] pcB;
   logic [DW-1:0] rnB, rmB;

   logic [VW-1:0] obsA, obsB;

   assign obsA = {validA, memRA, memWA, wbA, immA, bA, sA, cmdA, src1A, src2A, destA,
                  shA, simmA, pcA, rnA, rmA, srA};
   assign obsB = {validB, memRB, memWB, wbB, immB, bB, sB, cmdB, src1B, src2B, destB,
                  shB, simmB, pcB, rnB, rmB, srB};

   always #5 clk = ~clk;

   id_stage_gen2 #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .WB_BYPASS(1), .HAZ_MEM_CHECK(1)) dutA (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .PC_in(PC_in),
      .instruction_in(instruction_in), .Status_Register(Status_Register),
      .stall_in(stall_in), .flush(flush), .WB_EN(WB_EN), .WB_Dest(WB_Dest),
      .WB_Value(WB_Value), .EXE_WB_EN(EXE_WB_EN), .EXE_Dest(EXE_Dest),
      .MEM_WB_EN(MEM_WB_EN), .MEM_Dest(MEM_Dest), .hazard_out(hazA),
      .valid_out(validA), .MEM_R_EN_out(memRA), .MEM_W_EN_out(memWA),
      .WB_EN_out(wbA), .Imm_out(immA), .B_out(bA), .S_out(sA), .EX_CMD_out(cmdA),
      .Reg_src1(src1A), .Reg_src2(src2A), .Reg_Dest(destA), .shifter_operand(shA),
      .signed_immediate(simmA), .PC_out(pcA), .Val_Rn(rnA), .Val_Rm(rmA), .SR_out(srA));

   id_stage_gen2 #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .WB_BYPASS(0), .HAZ_MEM_CHECK(0)) dutB (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .PC_in(PC_in),
      .instruction_in(instruction_in), .Status_Register(Status_Register),
      .stall_in(stall_in), .flush(flush), .WB_EN(WB_EN), .WB_Dest(WB_Dest),
      .WB_Value(WB_Value), .EXE_WB_EN(EXE_WB_EN), .EXE_Dest(EXE_Dest),
      .MEM_WB_EN(MEM_WB_EN), .MEM_Dest(MEM_Dest), .hazard_out(hazB),
      .valid_out(validB), .MEM_R_EN_out(memRB), .MEM_W_EN_out(memWB),
      .WB_EN_out(wbB), .Imm_out(immB), .B_out(bB), .S_out(sB), .EX_CMD_out(cmdB),
      .Reg_src1(src1B), .Reg_src2(src2B), .Reg_Dest(destB), .shifter_operand(shB),
      .signed_immediate(simmB), .PC_out(pcB), .Val_Rn(rnB), .Val_Rm(rmB), .SR_out(srB));

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] modelRf [16];
   logic [VW-1:0] expVec [2];
   logic          expHaz [2];
   logic          obsHaz [2];
   logic [3:0]    aluCmd [16];
   bit            aluKnown [16];
   bit            aluWrites [16];

   // Opcode table: ALU command and whether the result is written back.
   task automatic initTables();
      for (int i = 0; i < 16; i++) begin
         aluCmd[i] = 4'b0000; aluKnown[i] = 1'b0; aluWrites[i] = 1'b0;
      end
      aluCmd[4'b1101] = 4'd1; aluCmd[4'b1111] = 4'd9; aluCmd[4'b0100] = 4'd2;
      aluCmd[4'b0101] = 4'd3; aluCmd[4'b0010] = 4'd4; aluCmd[4'b0110] = 4'd5;
      aluCmd[4'b0000] = 4'd6; aluCmd[4'b1100] = 4'd7; aluCmd[4'b0001] = 4'd8;
      aluCmd[4'b1010] = 4'd4; aluCmd[4'b1000] = 4'd6;
      foreach (aluKnown[i]) begin
         aluKnown[i]  = (i == 13 || i == 15 || i == 4 || i == 5 || i == 2 || i == 6 ||
                         i == 0 || i == 12 || i == 1 || i == 10 || i == 8);
         aluWrites[i] = aluKnown[i] && (i != 10) && (i != 8);
      end
      for (int i = 0; i < 16; i++) modelRf[i] = '0;
   endtask

   // Odd condition codes are the negation of the even code below them.
   function automatic bit condOk(input logic [3:0] c, input logic [3:0] sr);
      bit n, z, cf, v, base;
      {n, z, cf, v} = sr;
      if (c == 4'hE) return 1'b1;
      if (c == 4'hF) return 1'b0;
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cf;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cf && !z;
         3'd5: base = (n == v);
         default: base = !z && (n == v);
      endcase
      return c[0] ? !base : base;
   endfunction

   function automatic bit busy(input logic [3:0] r, input bit memChk);
      return (EXE_WB_EN && EXE_Dest == r) || (memChk && MEM_WB_EN && MEM_Dest == r);
   endfunction

   function automatic logic [VW-1:0] modelNext(input int k, output bit haz);
      bit byp, memChk, isAlu, isLoad, isStore, isBranch, useRn, useRm, ok, wb, s;
      logic [3:0] op, cmd, rn, rm;
      logic [DW-1:0] vn, vm;
      byp      = (k == 0);
      memChk   = (k == 0);
      op       = instruction_in[24:21];
      isAlu    = (instruction_in[27:26] == 2'b00);
      isLoad   = (instruction_in[27:26] == 2'b01) && instruction_in[20];
      isStore  = (instruction_in[27:26] == 2'b01) && !instruction_in[20];
      isBranch = (instruction_in[27:26] == 2'b10);
      cmd      = isAlu ? aluCmd[op] : ((isLoad || isStore) ? 4'd2 : 4'd0);
      wb       = isAlu ? aluWrites[op] : isLoad;
      s        = isAlu && aluKnown[op] && instruction_in[20];
      rn       = instruction_in[19:16];
      rm       = isStore ? instruction_in[15:12] : instruction_in[3:0];
      useRn    = !(isBranch || (isAlu && (op == 4'b1101 || op == 4'b1111)));
      useRm    = isStore || !instruction_in[25];
      haz      = instr_valid && !flush && ((useRn && busy(rn, memChk)) || (useRm && busy(rm, memChk)));
      vn       = (byp && WB_EN && WB_Dest == rn) ? WB_Value : modelRf[rn];
      vm       = (byp && WB_EN && WB_Dest == rm) ? WB_Value : modelRf[rm];
      ok       = condOk(instruction_in[31:28], Status_Register);
      if (rst) return '0;
      if (stall_in) return expVec[k];
      if (flush || !instr_valid || haz) return '0;
      return {1'b1, ok && isLoad, ok && isStore, ok && wb, ok && instruction_in[25],
              ok && isBranch, ok && s, ok ? cmd : 4'b0000, rn, rm, instruction_in[15:12],
              instruction_in[11:0], instruction_in[23:0], PC_in, vn, vm, Status_Register};
   endfunction

   // Runs one clock with the inputs currently driven and advances the model.
   task automatic applyStimulus();
      bit h0, h1;
      logic [VW-1:0] n0, n1;
      #2;
      n0 = modelNext(0, h0);
      n1 = modelNext(1, h1);
      expHaz[0] = h0;
      expHaz[1] = h1;
      obsHaz[0] = hazA;
      obsHaz[1] = hazB;
      @(posedge clk);
      expVec[0] = n0;
      expVec[1] = n1;
      if (rst) begin
         for (int i = 0; i < 16; i++) modelRf[i] = '0;
      end else if (WB_EN) begin
         modelRf[WB_Dest] = WB_Value;
      end
      @(negedge clk);
   endtask

   task automatic setIdle();
      rst = 1'b0; instr_valid = 1'b0; PC_in = '0; instruction_in = '0;
      Status_Register = 4'h0; stall_in = 1'b0; flush = 1'b0; WB_EN = 1'b0;
      WB_Dest = 4'h0; WB_Value = '0; EXE_WB_EN = 1'b0; EXE_Dest = 4'h0;
      MEM_WB_EN = 1'b0; MEM_Dest = 4'h0;
   endtask

   task automatic loadInstr(input logic [31:0] w, input logic [PW-1:0] pc);
      instr_valid = 1'b1; instruction_in = w; PC_in = pc;
   endtask

   task automatic test_reset();
      setIdle();
      rst = 1'b1;
      applyStimulus();
      applyStimulus();
      checks++;
      if (obsA !== '0 || obsB !== '0) begin
         errors++;
         $display("[TB] FAIL reset_state: got %h / %h want all zero", obsA, obsB);
      end
      checks++;
      if (obsHaz[0] !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_hazard: got %b want 0", obsHaz[0]);
      end
      rst = 1'b0;
   endtask

   task automatic test_add();
      WB_EN = 1'b1; WB_Dest = 4'd2; WB_Value = 32'd5;
      applyStimulus();
      WB_Dest = 4'd3; WB_Value = 32'd7;
      applyStimulus();
      WB_EN = 1'b0;
      loadInstr(32'hE0821003, 32'h100);
      applyStimulus();
      checks++;
      if (obsA !== expVec[0]) begin
         errors++; $display("[TB] FAIL add_model: got %h want %h", obsA, expVec[0]);
      end
      checks++;
      if ({validA, cmdA, wbA, rnA, rmA, destA} !== {1'b1, 4'b0010, 1'b1, 32'd5, 32'd7, 4'd1}) begin
         errors++;
         $display("[TB] FAIL add_fields: got v=%b cmd=%b wb=%b rn=%0d rm=%0d rd=%0d want 1 0010 1 5 7 1",
                  validA, cmdA, wbA, rnA, rmA, destA);
      end
   endtask

   task automatic test_raw_hazard();
      EXE_WB_EN = 1'b1; EXE_Dest = 4'd2;
      loadInstr(32'hE0821003, 32'h104);
      applyStimulus();
      checks++;
      if (obsHaz[0] !== 1'b1 || obsHaz[1] !== 1'b1) begin
         errors++; $display("[TB] FAIL raw_hazard: got %b%b want 11", obsHaz[0], obsHaz[1]);
      end
      checks++;
      if (obsA !== '0) begin
         errors++; $display("[TB] FAIL raw_bubble: got %h want zero", obsA);
      end
      EXE_WB_EN = 1'b0;
      applyStimulus();
      checks++;
      if (validA !== 1'b1 || obsA !== expVec[0]) begin
         errors++; $display("[TB] FAIL raw_release: got %h want %h", obsA, expVec[0]);
      end
   endtask

   task automatic test_mov_imm();
      EXE_WB_EN = 1'b1; EXE_Dest = 4'd0;
      loadInstr(32'hE3A04001, 32'h108);
      applyStimulus();
      checks++;
      if (obsHaz[0] !== 1'b0) begin
         errors++; $display("[TB] FAIL mov_hazard: got %b want 0", obsHaz[0]);
      end
      checks++;
      if ({validA, immA, cmdA, destA, wbA} !== {1'b1, 1'b1, 4'b0001, 4'd4, 1'b1}) begin
         errors++;
         $display("[TB] FAIL mov_fields: got v=%b imm=%b cmd=%b rd=%0d wb=%b want 1 1 0001 4 1",
                  validA, immA, cmdA, destA, wbA);
      end
      EXE_WB_EN = 1'b0;
   endtask

   task automatic test_bypass();
      WB_EN = 1'b1; WB_Dest = 4'd3; WB_Value = 32'hDEADBEEF;
      loadInstr(32'hE0821003, 32'h10C);
      applyStimulus();
      checks++;
      if (rmA !== 32'hDEADBEEF) begin
         errors++; $display("[TB] FAIL bypass_on: got %h want deadbeef", rmA);
      end
      checks++;
      if (rmB !== 32'd7) begin
         errors++; $display("[TB] FAIL bypass_off: got %h want 00000007", rmB);
      end
      WB_EN = 1'b0;
   endtask

   task automatic test_stall_flush();
      logic [VW-1:0] held;
      loadInstr(32'hE0821003, 32'h110);
      applyStimulus();
      held = expVec[0];
      stall_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         loadInstr($urandom, $urandom);
         applyStimulus();
         checks++;
         if (obsA !== held || obsB !== expVec[1]) begin
            errors++; $display("[TB] FAIL stall_hold%0d: got %h want %h", i, obsA, held);
         end
      end
      stall_in = 1'b0; flush = 1'b1;
      loadInstr(32'hE0821003, 32'h114);
      applyStimulus();
      checks++;
      if (validA !== 1'b0 || obsA !== '0) begin
         errors++; $display("[TB] FAIL flush_bubble: got %h want zero", obsA);
      end
      flush = 1'b0;
   endtask

   task automatic test_cond_fail();
      Status_Register = 4'b0000;
      loadInstr(32'h00921003, 32'h118);
      applyStimulus();
      checks++;
      if ({validA, wbA, memWA, sA, cmdA} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'b0000} || obsA !== expVec[0]) begin
         errors++;
         $display("[TB] FAIL cond_fail: got v=%b wb=%b mw=%b s=%b cmd=%b want 1 0 0 0 0000",
                  validA, wbA, memWA, sA, cmdA);
      end
      Status_Register = 4'b0100;
      applyStimulus();
      checks++;
      if ({validA, wbA, sA, cmdA} !== {1'b1, 1'b1, 1'b1, 4'b0010}) begin
         errors++;
         $display("[TB] FAIL cond_pass: got v=%b wb=%b s=%b cmd=%b want 1 1 1 0010",
                  validA, wbA, sA, cmdA);
      end
   endtask

   task automatic test_reset_in_stall();
      Status_Register = 4'h0;
      loadInstr(32'hE0821003, 32'h11C);
      applyStimulus();
      stall_in = 1'b1; rst = 1'b1;
      applyStimulus();
      checks++;
      if (obsA !== '0 || obsB !== '0) begin
         errors++; $display("[TB] FAIL reset_in_stall: got %h want zero", obsA);
      end
      stall_in = 1'b0; rst = 1'b0;
      loadInstr(32'hE0821003, 32'h120);
      applyStimulus();
      checks++;
      if ({validA, cmdA, rnA, rmA, pcA} !== {1'b1, 4'b0010, 32'd0, 32'd0, 32'h120}) begin
         errors++;
         $display("[TB] FAIL after_reset_load: got v=%b cmd=%b rn=%h rm=%h pc=%h",
                  validA, cmdA, rnA, rmA, pcA);
      end
   endtask

   function automatic logic [31:0] randInstr();
      logic [31:0] w;
      int unsigned r;
      w = $urandom;
      if ($urandom_range(3) != 0) w[31:28] = 4'hE;
      r = $urandom_range(9);
      if (r < 6)      w[27:26] = 2'b00;
      else if (r < 8) w[27:26] = 2'b01;
      else if (r < 9) w[27:26] = 2'b10;
      else            w[27:26] = 2'b11;
      return w;
   endfunction

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst             = ($urandom_range(63) == 0);
         instr_valid     = ($urandom_range(7) != 0);
         flush           = ($urandom_range(15) == 0);
         stall_in        = ($urandom_range(7) == 0);
         WB_EN           = $urandom_range(1);
         WB_Dest         = $urandom_range(15);
         WB_Value        = $urandom;
         EXE_WB_EN       = ($urandom_range(2) == 0);
         EXE_Dest        = $urandom_range(15);
         MEM_WB_EN       = ($urandom_range(2) == 0);
         MEM_Dest        = $urandom_range(15);
         Status_Register = $urandom_range(15);
         PC_in           = $urandom;
         instruction_in  = randInstr();
         applyStimulus();
         checks++;
         if (obsHaz[0] !== expHaz[0] || obsHaz[1] !== expHaz[1]) begin
            errors++;
            $display("[TB] FAIL rand_hazard@%0d: got %b%b want %b%b", n,
                     obsHaz[0], obsHaz[1], expHaz[0], expHaz[1]);
         end
         checks++;
         if (obsA !== expVec[0] || obsB !== expVec[1]) begin
            errors++;
            $display("[TB] FAIL rand_idex@%0d: got %h / %h want %h / %h", n,
                     obsA, obsB, expVec[0], expVec[1]);
         end
      end
   endtask

   initial begin
      initTables();
      setIdle();
      expVec[0] = '0;
      expVec[1] = '0;
      test_reset();
      test_add();
      test_raw_hazard();
      test_mov_imm();
      test_bypass();
      test_stall_flush();
      test_cond_fail();
      test_reset_in_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
